fwd_sel_mux: RTL
================

# fwd_sel_mux

Parametrised, pipelined operand-select multiplexer for the P4 stall/bypass datapath. It generalises the fixed 2/3-input forwarding muxes to N sources of W bits, with LAT registered stages. Each stage carries a valid bit and responds to pipeline stall and flush. Out-of-range selects have defined behaviour and are reported. It sits between the bypass-source buses (register file, E/M/W results) and the ALU/compare operand inputs.

## Interface
Parameters:
- W, 32, data width of each source and of the output
- N, 3, number of sources (2..16); SELW = max(1, clog2(N)) is derived, not overridable
- LAT, 1, number of register stages from input to output (1..4)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- din  input  N*W  packed sources; source i at din[i*W +: W]
- sel  input  SELW  source index
- in_valid  input  1  current beat is real (0 = bubble)
- stall  input  1  hold every stage
- flush  input  1  kill every in-flight beat
- out  output  W  selected data from the last stage
- out_valid  output  1  last-stage valid
- sel_err  output  1  sticky flag: an accepted beat used an out-of-range select
- err_cnt  output  8  saturating count of out-of-range accepted beats (present only with FWD_SEL_MUX_ERRCNT_EN)

## Operation
- Stage-0 pick is combinational:
  - pick = source[sel] when sel < N.
  - pick = source 0 when sel >= N. This case can occur only if N is not a power of 2.
- A pick never infers a latch. Every sel value drives a defined pick.
- Pipeline: stage k (1..LAT) holds {data_k, valid_k}. out = data_LAT and out_valid = valid_LAT.
- Per-cycle priority, applied identically to all stages:
  1. flush=1: all valid_k <= 0, data unchanged. The current input is dropped, even with stall=1 or in_valid=1.
  2. stall=1: all stages hold data and valid.
  3. Otherwise:
     - stage 1 <= {pick, in_valid};
     - stage k <= stage k-1 for k > 1.
- A bubble (in_valid=0) still shifts through. Its data field is the pick, but it is don't-care to consumers.
- Accepted beat = in_valid & ~stall & ~flush.
- Out-of-range event = accepted beat with sel >= N. It sets sel_err on the next edge. sel_err clears only on reset.
- No state machine beyond the valid pipeline and the error state.

## Timing
- Reset (rst_n=0, asynchronous): all data_k = 0, all valid_k = 0, sel_err = 0, err_cnt = 0. Outputs take these values immediately, without waiting for a clock edge.
- Release is synchronous to clk. The first capture happens on the first rising edge with rst_n=1.
- Latency: a beat accepted at edge t appears on out/out_valid after edge t+LAT-1. For LAT=1, it is visible in the cycle after the capturing edge.
- Each stall cycle adds exactly one cycle to the latency of every in-flight beat. Stall never creates, duplicates or loses a beat.
- Flush takes effect at the next edge: out_valid is 0 in the following cycle. With LAT>1, flush kills all LAT in-flight beats.
- flush and stall in the same cycle: flush wins.
- sel and din are sampled only at edges where the beat is accepted (stall=0). They may change freely during stall.
- Reset asserted mid-operation discards all in-flight beats and error state.

## Configuration
- FWD_SEL_MUX_ERRCNT_EN defined:
  - err_cnt port exists.
  - It increments by 1 on each out-of-range event and saturates at 255. It is never wrapped.
  - It is cleared only by reset.
- FWD_SEL_MUX_ERRCNT_EN undefined:
  - No err_cnt port and no counter logic.
  - sel_err behaviour is identical in both builds.

## Test plan
- Basic select, N=3, LAT=1: din = {0x33333333, 0x22222222, 0x11111111}, sel = 0, 1, 2 on consecutive cycles with in_valid=1 -> out = 0x11111111, 0x22222222, 0x33333333 on the next three cycles, out_valid=1 throughout.
- Out-of-range select, N=3: sel=3, in_valid=1 once -> out = source 0 one cycle later, sel_err=1 and stays 1; err_cnt=1 with the macro. Repeating 300 such beats -> err_cnt=255.
- Stall mid-stream, LAT=3: beats A, B, C, then stall for 2 cycles -> out_valid sequence 0,0,A,(hold),(hold),B,C. No beat is lost or duplicated, and out is steady during stall.
- Flush versus stall, LAT=2: pipeline full with A and B, then flush=1 and stall=1 in the same cycle -> out_valid=0 the next cycle; input beat offered that cycle never appears.
- Asynchronous reset mid-operation: rst_n driven low between clock edges while out_valid=1 and sel_err=1 -> out=0, out_valid=0, sel_err=0 before the next edge. After release, the first accepted beat emerges after LAT cycles.
- Bubble propagation, LAT=2: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed by 2 cycles, data matches the valid beats.

Source files
------------

// File: rtl/fwd_sel_mux.sv
// fwd_sel_mux: N-source, W-bit operand-select mux with LAT registered stages.
// Each stage carries a valid bit. Flush takes priority over stall, and stall
// takes priority over shifting. An out-of-range select on an accepted beat
// sets a sticky error flag.
// Optional build macro FWD_SEL_MUX_ERRCNT_EN adds the err_cnt port and a
// saturating 8-bit counter of out-of-range accepted beats.
module fwd_sel_mux #(
  parameter  int W    = 32,
  parameter  int N    = 3,
  parameter  int LAT  = 1,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*W-1:0]  din,
  input  logic [SELW-1:0] sel,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  output logic [W-1:0]    out,
  output logic            out_valid,
  output logic            sel_err
`ifdef FWD_SEL_MUX_ERRCNT_EN
  ,
  output logic [7:0]      err_cnt
`endif
);

  logic [W-1:0]          pick;
  logic                  sel_oor;
  logic                  accept;
  logic                  oor_evt;
  logic [LAT:1][W-1:0]   data_q, data_d;
  logic [LAT:1]          vld_pipe_q, vld_pipe_d;
  logic                  sel_err_q, sel_err_d;

  // Out-of-range selects are only possible when N is not a power of two.
  if (N < (1 << SELW)) begin : g_oor
    assign sel_oor = (sel >= SELW'(N));
  end else begin : g_no_oor
    assign sel_oor = 1'b0;
  end

  // Stage-0 pick: source 0 is the default, so every sel value drives a defined result.
  always_comb begin
    pick = din[W-1:0];
    for (int i = 1; i < N; i++)
      if (sel == SELW'(i)) pick = din[i*W +: W];
  end

  assign accept  = in_valid & ~stall & ~flush;
  assign oor_evt = accept & sel_oor;

  // Next pipeline state: flush kills valids, stall holds, otherwise shift.
  always_comb begin
    data_d     = data_q;
    vld_pipe_d = vld_pipe_q;
    if (flush) begin
      vld_pipe_d = '0;
    end else if (!stall) begin
      data_d[1]     = pick;
      vld_pipe_d[1] = in_valid;
      for (int k = 2; k <= LAT; k++) begin
        data_d[k]     = data_q[k-1];
        vld_pipe_d[k] = vld_pipe_q[k-1];
      end
    end
  end

  // Sticky error: once set, only reset clears it.
  always_comb begin
    sel_err_d = sel_err_q | oor_evt;
  end

  // Pipeline and error state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      vld_pipe_q <= '0;
      sel_err_q  <= 1'b0;
    end else begin
      data_q     <= data_d;
      vld_pipe_q <= vld_pipe_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign out       = data_q[LAT];
  assign out_valid = vld_pipe_q[LAT];
  assign sel_err   = sel_err_q;

`ifdef FWD_SEL_MUX_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating event counter; it holds at 255 and never wraps.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (oor_evt && (err_cnt_q != 8'hff)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
